trap_controller: RTL and testbench

Consumes the per-stage exception/return results that priv_control delivers at memory-receive, plus pending interrupts, and commits architectural trap state. It owns the privilege level, the mepc/sepc/mcause/scause registers and the mstatus trap-stack bits (MIE/MPIE/MPP/SIE/SPIE/SPP). It sequences pipeline flush and redirect through a small FSM, and drives priv, trap_branch, intr_branch and trap_target back to priv_control and fetch.

---
 rtl/priv_pkg.sv | 31 +++
 rtl/trap_cause_select.sv | 59 +++++
 rtl/trap_controller.sv | 217 +++++++++++++++++++++
 tb/tb_trap_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priv_pkg.sv
// Shared privilege, cause, trap-vector and FSM definitions for the trap path.
package priv_pkg;

   // Privilege level encodings
   localparam logic [1:0] PRIV_USER       = 2'b00;
   localparam logic [1:0] PRIV_SUPERVISOR = 2'b01;
   localparam logic [1:0] PRIV_MACHINE    = 2'b11;

   // Exception cause codes
   localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
   localparam logic [3:0] CAUSE_ECALL_S = 4'd9;
   localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
   localparam logic [3:0] CAUSE_INST_PF = 4'd12;
   localparam logic [3:0] CAUSE_LOAD_PF = 4'd13;

   // Interrupt cause codes (interrupt bit is added on top of these)
   localparam logic [3:0] INTR_M_CODE = 4'd11;
   localparam logic [3:0] INTR_S_CODE = 4'd9;

   // tvec mode field, held in bits [1:0] of mtvec/stvec
   localparam logic [1:0] TVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;
   localparam logic [1:0] TVEC_MODE_MASK     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_REDIRECT
   } trap_state_e;

endpackage

// File: rtl/trap_cause_select.sv
// Picks the trap to take this cycle: exception over xRET over interrupt
// (machine before supervisor), and decides delegation to S-mode.
module trap_cause_select
   import priv_pkg::*;
(
   input  logic        exception_i,
   input  logic [3:0]  exception_code_i,
   input  logic        m_ret_i,
   input  logic        s_ret_i,
   input  logic        mip_m_i,
   input  logic        mip_s_i,
   input  logic [15:0] medeleg_i,
   input  logic        mideleg_s_i,
   input  logic [1:0]  priv_i,
   input  logic        mie_i,
   input  logic        sie_i,
   output logic        take_o,
   output logic        is_intr_o,
   output logic        to_s_o,
   output logic [4:0]  cause_o
);

   logic m_intr_en;
   logic s_intr_en;

   // M interrupts are masked only while running in M with MIE clear.
   assign m_intr_en = (priv_i != PRIV_MACHINE) || mie_i;
   // An undelegated S interrupt follows the M-mode enable rule.
   assign s_intr_en = mideleg_s_i
                    ? ((priv_i == PRIV_USER) || ((priv_i == PRIV_SUPERVISOR) && sie_i))
                    : m_intr_en;

   // Priority resolution and delegation decision
   always_comb begin
      // NOTE: every output gets a default before the if-chain, otherwise an
      // unassigned path would infer a latch.
      take_o    = 1'b0;
      is_intr_o = 1'b0;
      to_s_o    = 1'b0;
      cause_o   = '0;
      if (exception_i) begin
         take_o  = 1'b1;
         cause_o = {1'b0, exception_code_i};
         to_s_o  = (priv_i != PRIV_MACHINE) && medeleg_i[exception_code_i];
      end else if (!m_ret_i && !s_ret_i) begin
         if (mip_m_i && m_intr_en) begin
            take_o    = 1'b1;
            is_intr_o = 1'b1;
            cause_o   = {1'b1, INTR_M_CODE};
         end else if (mip_s_i && s_intr_en) begin
            take_o    = 1'b1;
            is_intr_o = 1'b1;
            cause_o   = {1'b1, INTR_S_CODE};
            to_s_o    = mideleg_s_i;
         end
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Commits trap/xRET architectural state and sequences flush -> redirect.
// Optional build macro VECTORED_INTR_EN: vectored interrupt targets when a
// tvec mode field is 2'b01; without it every trap goes to the tvec base.
module trap_controller
   import priv_pkg::*;
#(
   parameter int ADDRESS_BITS = 20,
   parameter int FLUSH_CYCLES = 2,
   parameter int CORE         = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    exception_memory_receive,
   input  logic [3:0]              exception_code_memory_receive,
   input  logic [ADDRESS_BITS-1:0] inst_PC_memory_receive,
   input  logic                    m_ret_memory_receive,
   input  logic                    s_ret_memory_receive,
   input  logic                    mip_m,
   input  logic                    mip_s,
   input  logic [15:0]             medeleg,
   input  logic                    mideleg_s,
   input  logic [ADDRESS_BITS-1:0] mtvec,
   input  logic [ADDRESS_BITS-1:0] stvec,
   output logic [1:0]              priv,
   output logic                    flush,
   output logic                    trap_branch,
   output logic                    intr_branch,
   output logic [ADDRESS_BITS-1:0] trap_target,
   output logic [ADDRESS_BITS-1:0] mepc,
   output logic [ADDRESS_BITS-1:0] sepc,
   output logic [4:0]              mcause,
   output logic [4:0]              scause,
   output logic [5:0]              mstatus_bits,
   output logic                    sie
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [ADDRESS_BITS-1:0] MODE_MASK = ADDRESS_BITS'(TVEC_MODE_MASK);

   if (FLUSH_CYCLES < 1 || CORE < 0) begin : g_param_check
      $error("trap_controller core %0d: FLUSH_CYCLES must be >= 1", CORE);
   end

   trap_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              priv_q, priv_d;
   logic [ADDRESS_BITS-1:0] mepc_q, mepc_d, sepc_q, sepc_d;
   logic [4:0]              mcause_q, mcause_d, scause_q, scause_d;
   logic                    mie_q, mie_d, sie_q, sie_d;
   logic                    mpie_q, mpie_d, spie_q, spie_d;
   logic [1:0]              mpp_q, mpp_d;
   logic                    spp_q, spp_d;
   logic                    intr_q, intr_d;
   logic [ADDRESS_BITS-1:0] target_q, target_d;

   logic                    take, is_intr, to_s;
   logic [4:0]              cause;
   logic [ADDRESS_BITS-1:0] tvec_sel, vec_base, trap_vec;

   trap_cause_select u_cause_select (
      .exception_i      (exception_memory_receive),
      .exception_code_i (exception_code_memory_receive),
      .m_ret_i          (m_ret_memory_receive),
      .s_ret_i          (s_ret_memory_receive),
      .mip_m_i          (mip_m),
      .mip_s_i          (mip_s),
      .medeleg_i        (medeleg),
      .mideleg_s_i      (mideleg_s),
      .priv_i           (priv_q),
      .mie_i            (mie_q),
      .sie_i            (sie_q),
      .take_o           (take),
      .is_intr_o        (is_intr),
      .to_s_o           (to_s),
      .cause_o          (cause)
   );

   assign tvec_sel = to_s ? stvec : mtvec;
   assign vec_base = tvec_sel & ~MODE_MASK;
`ifdef VECTORED_INTR_EN
   logic [ADDRESS_BITS-1:0] vec_offset;
   assign vec_offset = ADDRESS_BITS'({cause[3:0], 2'b00});
   assign trap_vec   = (is_intr && (tvec_sel[1:0] == TVEC_MODE_VECTORED))
                     ? vec_base + vec_offset : vec_base;
`else
   assign trap_vec   = vec_base;
`endif

   // Next-state logic: event commit in IDLE, flush countdown, redirect strobe
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      priv_d      = priv_q;
      mepc_d      = mepc_q;
      sepc_d      = sepc_q;
      mcause_d    = mcause_q;
      scause_d    = scause_q;
      mie_d       = mie_q;
      sie_d       = sie_q;
      mpie_d      = mpie_q;
      spie_d      = spie_q;
      mpp_d       = mpp_q;
      spp_d       = spp_q;
      intr_d      = intr_q;
      target_d    = target_q;
      flush       = 1'b0;
      trap_branch = 1'b0;
      intr_branch = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d  = ST_FLUSH;
               cnt_d    = CNT_LOAD;
               intr_d   = is_intr;
               target_d = trap_vec;
               if (to_s) begin
                  sepc_d   = inst_PC_memory_receive;
                  scause_d = cause;
                  spp_d    = priv_q[0];
                  spie_d   = sie_q;
                  sie_d    = 1'b0;
                  priv_d   = PRIV_SUPERVISOR;
               end else begin
                  mepc_d   = inst_PC_memory_receive;
                  mcause_d = cause;
                  mpp_d    = priv_q;
                  mpie_d   = mie_q;
                  mie_d    = 1'b0;
                  priv_d   = PRIV_MACHINE;
               end
            end else if (m_ret_memory_receive) begin
               state_d  = ST_FLUSH;
               cnt_d    = CNT_LOAD;
               intr_d   = 1'b0;
               target_d = mepc_q;
               priv_d   = mpp_q;
               mie_d    = mpie_q;
               mpie_d   = 1'b1;
               mpp_d    = PRIV_USER;
            end else if (s_ret_memory_receive) begin
               state_d  = ST_FLUSH;
               cnt_d    = CNT_LOAD;
               intr_d   = 1'b0;
               target_d = sepc_q;
               priv_d   = {1'b0, spp_q};
               sie_d    = spie_q;
               spie_d   = 1'b1;
               spp_d    = 1'b0;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_REDIRECT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_REDIRECT: begin
            trap_branch = !intr_q;
            intr_branch = intr_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         priv_q   <= PRIV_MACHINE;
         mepc_q   <= '0;
         sepc_q   <= '0;
         mcause_q <= '0;
         scause_q <= '0;
         mie_q    <= 1'b0;
         sie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         spie_q   <= 1'b0;
         mpp_q    <= PRIV_USER;
         spp_q    <= 1'b0;
         intr_q   <= 1'b0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         priv_q   <= priv_d;
         mepc_q   <= mepc_d;
         sepc_q   <= sepc_d;
         mcause_q <= mcause_d;
         scause_q <= scause_d;
         mie_q    <= mie_d;
         sie_q    <= sie_d;
         mpie_q   <= mpie_d;
         spie_q   <= spie_d;
         mpp_q    <= mpp_d;
         spp_q    <= spp_d;
         intr_q   <= intr_d;
         target_q <= target_d;
      end
   end

   assign priv         = priv_q;
   assign trap_target  = target_q;
   assign mepc         = mepc_q;
   assign sepc         = sepc_q;
   assign mcause       = mcause_q;
   assign scause       = scause_q;
   assign mstatus_bits = {mpp_q, spp_q, mpie_q, spie_q, mie_q};
   assign sie          = sie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: trap entry, delegation, xRET,
// interrupts, masking, event collisions and reset during flush.
module tb_trap_controller;

   localparam int AW = 20;

   logic          clock;
   logic          reset;
   logic          exception_memory_receive;
   logic [3:0]    exception_code_memory_receive;
   logic [AW-1:0] inst_PC_memory_receive;
   logic          m_ret_memory_receive;
   logic          s_ret_memory_receive;
   logic          mip_m;
   logic          mip_s;
   logic [15:0]   medeleg;
   logic          mideleg_s;
   logic [AW-1:0] mtvec;
   logic [AW-1:0] stvec;
   logic [1:0]    priv;
   logic          flush;
   logic          trap_branch;
   logic          intr_branch;
   logic [AW-1:0] trap_target;
   logic [AW-1:0] mepc;
   logic [AW-1:0] sepc;
   logic [4:0]    mcause;
   logic [4:0]    scause;
   logic [5:0]    mstatus_bits;
   logic          sie;

   int vectors     = 0;
   int miscompares = 0;

   trap_controller #(.ADDRESS_BITS(AW), .FLUSH_CYCLES(2), .CORE(0)) dut (
      .clock                         (clock),
      .reset                         (reset),
      .exception_memory_receive      (exception_memory_receive),
      .exception_code_memory_receive (exception_code_memory_receive),
      .inst_PC_memory_receive        (inst_PC_memory_receive),
      .m_ret_memory_receive          (m_ret_memory_receive),
      .s_ret_memory_receive          (s_ret_memory_receive),
      .mip_m                         (mip_m),
      .mip_s                         (mip_s),
      .medeleg                       (medeleg),
      .mideleg_s                     (mideleg_s),
      .mtvec                         (mtvec),
      .stvec                         (stvec),
      .priv                          (priv),
      .flush                         (flush),
      .trap_branch                   (trap_branch),
      .intr_branch                   (intr_branch),
      .trap_target                   (trap_target),
      .mepc                          (mepc),
      .sepc                          (sepc),
      .mcause                        (mcause),
      .scause                        (scause),
      .mstatus_bits                  (mstatus_bits),
      .sie                           (sie)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_events();
      exception_memory_receive      = 1'b0;
      exception_code_memory_receive = 4'd0;
      m_ret_memory_receive          = 1'b0;
      s_ret_memory_receive          = 1'b0;
      mip_m                         = 1'b0;
      mip_s                         = 1'b0;
   endtask

   // Called one cycle after the event edge: two flush cycles, then one strobe.
   task automatic expect_redirect(input string tag, input logic intr, input logic [AW-1:0] tgt);
      check({tag, " flush c1"}, flush, 1'b1);
      check({tag, " no strobe c1"}, {trap_branch, intr_branch}, 2'b00);
      tick();
      check({tag, " flush c2"}, flush, 1'b1);
      tick();
      check({tag, " flush c3"}, flush, 1'b0);
      check({tag, " trap_branch"}, trap_branch, !intr);
      check({tag, " intr_branch"}, intr_branch, intr);
      check({tag, " target"}, trap_target, tgt);
      tick();
      check({tag, " strobes idle"}, {flush, trap_branch, intr_branch}, 3'b000);
   endtask

   initial begin
      int tb_count;
      int ib_count;
      int fl_count;
      logic [AW-1:0] seen_target;

      reset     = 1'b1;
      medeleg   = 16'h0000;
      mideleg_s = 1'b0;
      mtvec     = 20'h00800;
      stvec     = 20'h00400;
      inst_PC_memory_receive = '0;
      clear_events();
      tick();
      tick();
      reset = 1'b0;
      repeat (5) tick();

      // Reset state
      check("reset priv", priv, 2'b11);
      check("reset strobes", {flush, trap_branch, intr_branch}, 3'b000);
      check("reset mepc", mepc, 20'h0);
      check("reset mcause", mcause, 5'h00);
      check("reset mstatus", mstatus_bits, 6'h00);
      check("reset target", trap_target, 20'h0);

      // MRET from reset: MPP=U -> priv U, MIE=MPIE(0), MPIE=1
      m_ret_memory_receive = 1'b1;
      tick();
      clear_events();
      check("mret1 priv", priv, 2'b00);
      check("mret1 mstatus", mstatus_bits, 6'h04);
      expect_redirect("mret1", 1'b0, 20'h0);

      // Second MRET: MIE picks up MPIE=1
      m_ret_memory_receive = 1'b1;
      tick();
      clear_events();
      check("mret2 mstatus", mstatus_bits, 6'h05);
      expect_redirect("mret2", 1'b0, 20'h0);

      // U-mode ecall, delegated to S
      medeleg                       = 16'h0100;
      exception_memory_receive      = 1'b1;
      exception_code_memory_receive = 4'd8;
      inst_PC_memory_receive        = 20'h00200;
      tick();
      clear_events();
      check("deleg priv", priv, 2'b01);
      check("deleg sepc", sepc, 20'h00200);
      check("deleg scause", scause, 5'h08);
      check("deleg mstatus", mstatus_bits, 6'h05);
      check("deleg mepc untouched", mepc, 20'h0);
      expect_redirect("deleg", 1'b0, 20'h00400);

      // S-mode exception code 9, not delegated -> M
      exception_memory_receive      = 1'b1;
      exception_code_memory_receive = 4'd9;
      inst_PC_memory_receive        = 20'h00100;
      tick();
      clear_events();
      check("s2m priv", priv, 2'b11);
      check("s2m mepc", mepc, 20'h00100);
      check("s2m mcause", mcause, 5'h09);
      check("s2m mstatus", mstatus_bits, 6'h14);
      expect_redirect("s2m", 1'b0, 20'h00800);

      // MRET back to S with MIE restored
      m_ret_memory_receive = 1'b1;
      tick();
      clear_events();
      check("mret3 priv", priv, 2'b01);
      check("mret3 mstatus", mstatus_bits, 6'h05);
      expect_redirect("mret3", 1'b0, 20'h00100);

      // Machine interrupt taken from S
      mtvec                  = 20'h00801;
      mip_m                  = 1'b1;
      inst_PC_memory_receive = 20'h00180;
      tick();
      clear_events();
      check("mint priv", priv, 2'b11);
      check("mint mepc", mepc, 20'h00180);
      check("mint mcause", mcause, 5'h1B);
      check("mint mstatus", mstatus_bits, 6'h14);
`ifdef VECTORED_INTR_EN
      expect_redirect("mint", 1'b1, 20'h0082C);
`else
      expect_redirect("mint", 1'b1, 20'h00800);
`endif

      // Interrupts masked in M with MIE=0, S interrupt delegated
      mip_m     = 1'b1;
      mip_s     = 1'b1;
      mideleg_s = 1'b1;
      fl_count  = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (flush) fl_count++;
      end
      clear_events();
      mideleg_s = 1'b0;
      check("masked no flush", fl_count, 0);
      check("masked mcause", mcause, 5'h1B);
      check("masked scause", scause, 5'h08);

      // Exception + MRET together, then a second exception during FLUSH
      mtvec                         = 20'h00800;
      exception_memory_receive      = 1'b1;
      exception_code_memory_receive = 4'd2;
      m_ret_memory_receive          = 1'b1;
      inst_PC_memory_receive        = 20'h00300;
      tick();
      exception_code_memory_receive = 4'd5;
      inst_PC_memory_receive        = 20'h00400;
      tick();
      clear_events();
      tb_count    = 0;
      ib_count    = 0;
      seen_target = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (trap_branch) begin
            tb_count++;
            seen_target = trap_target;
         end
         if (intr_branch) ib_count++;
      end
      check("collide trap strobes", tb_count, 1);
      check("collide intr strobes", ib_count, 0);
      check("collide target", seen_target, 20'h00800);
      check("collide mepc", mepc, 20'h00300);
      check("collide mcause", mcause, 5'h02);
      check("collide mstatus", mstatus_bits, 6'h30);
      check("collide priv", priv, 2'b11);

      // Reset asserted during FLUSH: no strobe, state back to reset values
      exception_memory_receive      = 1'b1;
      exception_code_memory_receive = 4'd3;
      inst_PC_memory_receive        = 20'h00500;
      tick();
      clear_events();
      check("rstmid flush", flush, 1'b1);
      check("rstmid mepc", mepc, 20'h00500);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      tb_count = 0;
      fl_count = 0;
      for (int i = 0; i < 4; i++) begin
         if (trap_branch || intr_branch) tb_count++;
         if (flush) fl_count++;
         tick();
      end
      check("rstmid no strobe", tb_count, 0);
      check("rstmid no flush", fl_count, 0);
      check("rstmid priv", priv, 2'b11);
      check("rstmid mepc", mepc, 20'h0);
      check("rstmid mstatus", mstatus_bits, 6'h00);

      // MRET to U, then delegated S interrupt from U
      m_ret_memory_receive = 1'b1;
      tick();
      clear_events();
      expect_redirect("mret4", 1'b0, 20'h0);
      mideleg_s              = 1'b1;
      mip_s                  = 1'b1;
      inst_PC_memory_receive = 20'h00240;
      tick();
      clear_events();
      check("sint priv", priv, 2'b01);
      check("sint sepc", sepc, 20'h00240);
      check("sint scause", scause, 5'h19);
      check("sint mstatus", mstatus_bits, 6'h04);
      check("sint sie", sie, 1'b0);
      expect_redirect("sint", 1'b1, 20'h00400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
